// File: rtl/sram_tiled_pkg.sv
// ---------------------------------------------------------------------------
// sram_tiled_pkg
// Shared types and sizing helpers for the tiled SRAM bank array.
//   s1_req_t : control part of the registered request stage
//   s2_tag_t : control part of the registered read tag stage
//   calc_cols / calc_bank_sel_width : derive tiling geometry from parameters
// The width-dependent payload (bank, row, write data, byte-write enables)
// is parameter-sized, so it lives next to these structs in the top module.
// ---------------------------------------------------------------------------
package sram_tiled_pkg;

  typedef struct packed {
    logic valid;
    logic wr;
    logic oor;
  } s1_req_t;

  typedef struct packed {
    logic valid;
    logic oor;
  } s2_tag_t;

  // Number of macro columns tiled across the user word.
  function automatic int calc_cols(input int data_width, input int macro_data_width);
    return data_width / macro_data_width;
  endfunction

  // Width of the bank-select field sitting above the macro row address.
  function automatic int calc_bank_sel_width(input int addr_width, input int macro_addr_width);
    return addr_width - macro_addr_width;
  endfunction

endpackage

// File: rtl/TS1N16FFCLLSBLVTC2048X64M8SW.sv
// ---------------------------------------------------------------------------
// TS1N16FFCLLSBLVTC2048X64M8SW
// Behavioural stand-in for the 2048x64 single-port hard macro, used when the
// vendor library is not linked (simulation / FPGA prototyping). Leave this
// file out of any flow that links the real macro.
// Ports: CLK clock; CEB chip enable (active low); WEB write enable (active
// low); A row address; D write data; BWEB per-bit write enable (active low);
// RTSEL/WTSEL timing trims (no effect here); Q read data, updated only by a
// read and held otherwise.
// ---------------------------------------------------------------------------
module TS1N16FFCLLSBLVTC2048X64M8SW (
  input  logic        CLK,
  input  logic        CEB,
  input  logic        WEB,
  input  logic [10:0] A,
  input  logic [63:0] D,
  input  logic [63:0] BWEB,
  input  logic [1:0]  RTSEL,
  input  logic [1:0]  WTSEL,
  output logic [63:0] Q
);

  logic [63:0] mem [2048];
  logic        unused_trim;

  assign unused_trim = ^{RTSEL, WTSEL};

  always_ff @(posedge CLK) begin
    if (!CEB) begin
      if (!WEB) begin
        for (int i = 0; i < 64; i++) begin
          if (!BWEB[i]) mem[A][i] <= D[i];
        end
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/sram_bank_tile.sv
// ---------------------------------------------------------------------------
// sram_bank_tile
// One depth bank: COLS single-port macros side by side sharing one chip
// enable, write enable and row address. D/BWEB are sliced per column and the
// column Q outputs are concatenated back into one user-width word.
// Ports: clk; ceb/web (active low); a row address; d write data; bweb per-bit
// write enable (active low); q concatenated read data.
// ---------------------------------------------------------------------------
module sram_bank_tile #(
  parameter int MACRO_ADDR_WIDTH = 11,
  parameter int MACRO_DATA_WIDTH = 64,
  parameter int COLS             = 1
) (
  input  logic                               clk,
  input  logic                               ceb,
  input  logic                               web,
  input  logic [MACRO_ADDR_WIDTH-1:0]        a,
  input  logic [COLS*MACRO_DATA_WIDTH-1:0]   d,
  input  logic [COLS*MACRO_DATA_WIDTH-1:0]   bweb,
  output logic [COLS*MACRO_DATA_WIDTH-1:0]   q
);

  localparam int MDW = MACRO_DATA_WIDTH;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      if (MACRO_ADDR_WIDTH == 11 && MACRO_DATA_WIDTH == 64) begin : g_hard
        TS1N16FFCLLSBLVTC2048X64M8SW u_macro (
          .CLK   (clk),
          .CEB   (ceb),
          .WEB   (web),
          .A     (a),
          .D     (d[gi*MDW +: MDW]),
          .BWEB  (bweb[gi*MDW +: MDW]),
          .RTSEL (2'b01),
          .WTSEL (2'b00),
          .Q     (q[gi*MDW +: MDW])
        );
      end else begin : g_model
        // Same access semantics as the hard macro: registered read, Q held
        // across writes and idle cycles.
        logic [MDW-1:0] mem [2**MACRO_ADDR_WIDTH];
        logic [MDW-1:0] q_reg;

        always_ff @(posedge clk) begin
          if (!ceb) begin
            if (!web) begin
              for (int i = 0; i < MDW; i++) begin
                if (!bweb[gi*MDW + i]) mem[a][i] <= d[gi*MDW + i];
              end
            end else begin
              q_reg <= mem[a];
            end
          end
        end

        assign q[gi*MDW +: MDW] = q_reg;
      end
    end
  endgenerate

endmodule

// File: rtl/sram_tiled_bank_array.sv
// ---------------------------------------------------------------------------
// sram_tiled_bank_array
// Depth x width tiled SRAM behind a valid/ready request port and a
// valid/ready read-response port. Two register stages (request, read tag)
// feed an in-order response FIFO; credits keep the FIFO from overflowing.
// Ports:
//   CLK, reset                : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake
//   req_wr, req_addr          : 1=write / 0=read, word address
//   req_wdata, req_bmask      : write data, active-high bit write enable
//   rd_valid/rd_ready         : response handshake
//   rd_data, rd_err           : read data, out-of-range flag
// ---------------------------------------------------------------------------
module sram_tiled_bank_array
  import sram_tiled_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int ADDR_WIDTH       = 15,
  parameter int NUM_BANKS        = 12,
  parameter int MACRO_ADDR_WIDTH = 11,
  parameter int MACRO_DATA_WIDTH = 64,
  parameter int OUT_DEPTH        = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bmask,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_err
);

  localparam int COLS  = calc_cols(DATA_WIDTH, MACRO_DATA_WIDTH);
  localparam int BSW   = calc_bank_sel_width(ADDR_WIDTH, MACRO_ADDR_WIDTH);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  generate
    if (DATA_WIDTH % MACRO_DATA_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of MACRO_DATA_WIDTH");
    end
    if (BSW < 1 || NUM_BANKS * (2**MACRO_ADDR_WIDTH) > 2**ADDR_WIDTH) begin : g_bad_depth
      $error("NUM_BANKS * 2**MACRO_ADDR_WIDTH must fit in 2**ADDR_WIDTH");
    end
    if (OUT_DEPTH < 3) begin : g_bad_fifo
      $error("OUT_DEPTH must be at least 3");
    end
  endgenerate

  // Pipeline state
  logic                        reset_q;
  s1_req_t                     s1_reg;
  logic [BSW-1:0]              s1_bank_reg;
  logic [MACRO_ADDR_WIDTH-1:0] s1_row_reg;
  logic [DATA_WIDTH-1:0]       s1_wdata_reg;
  logic [DATA_WIDTH-1:0]       s1_bweb_reg;
  s2_tag_t                     s2_reg;
  logic [BSW-1:0]              s2_bank_reg;

  // Response FIFO: {err, data} per entry
  logic [DATA_WIDTH:0]         fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_reg;
  logic [PTR_W-1:0]            rd_ptr_reg;
  logic [CNT_W-1:0]            count_reg;

  logic [BSW-1:0]              req_bank;
  logic                        req_oor;
  logic                        accept;
  logic                        s1_rd;
  logic [CNT_W:0]              outstanding;
  logic                        s1_active;
  logic                        macro_web;
  logic [DATA_WIDTH-1:0]       macro_bweb;
  logic [NUM_BANKS-1:0]        bank_ceb;
  logic [NUM_BANKS-1:0]        bank_hit;
  logic [DATA_WIDTH-1:0]       bank_q [NUM_BANKS];
  logic [DATA_WIDTH-1:0]       sel_q;
  logic                        push;
  logic                        pop;
  logic [DATA_WIDTH:0]         head;

  assign req_bank = req_addr[ADDR_WIDTH-1:MACRO_ADDR_WIDTH];
  // One extra bit so NUM_BANKS == 2**BSW does not wrap to zero.
  assign req_oor  = {1'b0, req_bank} >= (BSW+1)'(NUM_BANKS);

  // Every read still owed a response holds a credit from acceptance to pop.
  assign s1_rd       = s1_reg.valid && !s1_reg.wr;
  assign outstanding = {1'b0, count_reg} + (CNT_W+1)'(s1_rd) + (CNT_W+1)'(s2_reg.valid);
  assign req_ready   = !reset && !reset_q && (req_wr || (outstanding < (CNT_W+1)'(OUT_DEPTH)));
  assign accept      = req_valid && req_ready;

  always_ff @(posedge CLK) begin
    reset_q <= reset;
    if (reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg.valid <= accept;
      if (accept) begin
        s1_reg.wr  <= req_wr;
        s1_reg.oor <= req_oor;
      end
      s2_reg.valid <= s1_rd;
      s2_reg.oor   <= s1_reg.oor;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      s1_bank_reg  <= req_bank;
      s1_row_reg   <= req_addr[MACRO_ADDR_WIDTH-1:0];
      s1_wdata_reg <= req_wdata;
      s1_bweb_reg  <= ~req_bmask;
    end
    s2_bank_reg <= s1_bank_reg;
  end

  // Macro controls are idle whenever S1 is empty, out of range, or in reset.
  assign s1_active  = s1_reg.valid && !s1_reg.oor && !reset;
  assign macro_web  = !(s1_active && s1_reg.wr);
  assign macro_bweb = s1_active ? s1_bweb_reg : '1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      assign bank_ceb[gi] = !(s1_active && (s1_bank_reg == BSW'(gi)));
      assign bank_hit[gi] = (s2_bank_reg == BSW'(gi));

      sram_bank_tile #(
        .MACRO_ADDR_WIDTH (MACRO_ADDR_WIDTH),
        .MACRO_DATA_WIDTH (MACRO_DATA_WIDTH),
        .COLS             (COLS)
      ) u_tile (
        .clk  (CLK),
        .ceb  (bank_ceb[gi]),
        .web  (macro_web),
        .a    (s1_row_reg),
        .d    (s1_wdata_reg),
        .bweb (macro_bweb),
        .q    (bank_q[gi])
      );
    end
  endgenerate

  always_comb begin
    sel_q = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_hit[b]) sel_q = sel_q | bank_q[b];
    end
  end

  assign push = s2_reg.valid;
  assign pop  = rd_valid && rd_ready;

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_reg] <= {s2_reg.oor, s2_reg.oor ? '0 : sel_q};
  end

  assign head     = fifo_mem[rd_ptr_reg];
  assign rd_valid = !reset && (count_reg != '0);
  assign rd_data  = rd_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rd_err   = rd_valid && head[DATA_WIDTH];

  fifo_no_overflow: assert property (@(posedge CLK) disable iff (reset)
    !(push && !pop && (count_reg == CNT_W'(OUT_DEPTH))));

endmodule

// File: tb/tb_sram_tiled_bank_array.sv
// ---------------------------------------------------------------------------
// tb_sram_tiled_bank_array
// Drives the tiled SRAM (128-bit user word, two macro columns) one cycle at a
// time and compares every observable output against a transaction-level
// model: an associative memory, a queue of owed read responses with their
// earliest visible cycle, and credit accounting from that queue.
// ---------------------------------------------------------------------------
module tb_sram_tiled_bank_array;

  localparam int DW  = 128;
  localparam int AW  = 15;
  localparam int NB  = 12;
  localparam int MAW = 11;
  localparam int OD  = 4;

  logic          CLK;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_bmask;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_err;

  sram_tiled_bank_array #(
    .DATA_WIDTH       (DW),
    .ADDR_WIDTH       (AW),
    .NUM_BANKS        (NB),
    .MACRO_ADDR_WIDTH (MAW),
    .MACRO_DATA_WIDTH (64),
    .OUT_DEPTH        (OD)
  ) u_dut (
    .CLK       (CLK),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_bmask (req_bmask),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_err    (rd_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            rdy;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [int];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic          prev_rst = 1'b1;
  logic          prev_acc = 1'b0;
  logic          prev_oor = 1'b0;
  int            prev_bank = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic is_oor(input logic [AW-1:0] a);
    return int'(a >> MAW) >= NB;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, update
  // the model with what the handshakes imply, then advance one edge.
  task automatic step(input logic rst, input logic v, input logic wr,
                      input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [DW-1:0] bm, input logic rr,
                      output logic acc, output logic acc_dut);
    logic          exp_ready;
    logic          exp_valid;
    logic [NB-1:0] exp_ceb;
    exp_t          e;
    reset = rst; req_valid = v; req_wr = wr; req_addr = addr;
    req_wdata = wd; req_bmask = bm; rd_ready = rr;
    #1;
    exp_ready = !rst && !prev_rst && (wr || exp_q.size() < OD);
    exp_valid = !rst && exp_q.size() > 0 && exp_q[0].rdy <= cyc;
    check("req_ready", DW'(req_ready), DW'(exp_ready));
    check("rd_valid", DW'(rd_valid), DW'(exp_valid));
    if (exp_valid) begin
      check("rd_data", rd_data, exp_q[0].data);
      check("rd_err", DW'(rd_err), DW'(exp_q[0].err));
    end else if (rst) begin
      check("rd_data_rst", rd_data, '0);
      check("rd_err_rst", DW'(rd_err), '0);
    end
    exp_ceb = '1;
    if (prev_acc && !prev_oor && !rst) exp_ceb[prev_bank] = 1'b0;
    check("bank_ceb", DW'(u_dut.bank_ceb), DW'(exp_ceb));

    acc     = v && exp_ready;
    acc_dut = v && req_ready;
    if (exp_valid && rr) begin
      $display("[%0d] resp data=%h err=%0d", cyc, exp_q[0].data, exp_q[0].err);
      void'(exp_q.pop_front());
    end
    if (acc) begin
      if (wr) begin
        if (!is_oor(addr)) ref_mem[int'(addr)] = (ref_mem[int'(addr)] & ~bm) | (wd & bm);
        $display("[%0d] write addr=%h data=%h mask=%h", cyc, addr, wd, bm);
      end else begin
        e.err  = is_oor(addr);
        e.data = e.err ? '0 : ref_mem[int'(addr)];
        e.rdy  = cyc + 3;
        exp_q.push_back(e);
        $display("[%0d] read  addr=%h", cyc, addr);
      end
    end
    prev_acc  = acc;
    prev_oor  = is_oor(addr);
    prev_bank = int'(addr >> MAW);
    prev_rst  = rst;
    @(posedge CLK);
    cyc++;
    if (rst) exp_q.delete();
    @(negedge CLK);
  endtask

  task automatic idle(input logic rr);
    logic a, ad;
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, rr, a, ad);
  endtask

  task automatic drain();
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) idle(1'b1);
    idle(1'b1);
  endtask

  initial begin
    logic          acc, acc_dut;
    int            k, n_dut;
    logic [AW-1:0] t4_addr [6];
    logic [AW-1:0] pool [12];
    logic [AW-1:0] a, last_a;
    logic [DW-1:0] bm;

    reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_bmask = '0; rd_ready = 1'b0;
    @(negedge CLK);

    // Reset window and the cycle after it
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, acc, acc_dut);
    idle(1'b1);
    idle(1'b1);

    // Write then read back address 0
    step(1'b0, 1'b1, 1'b1, 15'h0000, {64'hCAFE_F00D_1234_5678, 64'hDEAD_BEEF_0000_0001}, '1, 1'b1, acc, acc_dut);
    step(1'b0, 1'b1, 1'b0, 15'h0000, '0, '0, 1'b1, acc, acc_dut);
    drain();

    // Partial bit-mask write into bank 11
    step(1'b0, 1'b1, 1'b1, 15'h5801, {2{64'hAAAA_AAAA_BBBB_BBBB}}, '1, 1'b1, acc, acc_dut);
    step(1'b0, 1'b1, 1'b1, 15'h5801, {2{64'h1111_1111_2222_2222}}, {2{64'h0000_0000_FFFF_FFFF}}, 1'b1, acc, acc_dut);
    step(1'b0, 1'b1, 1'b0, 15'h5801, '0, '0, 1'b1, acc, acc_dut);
    drain();

    // Out-of-range write is dropped, read returns zeros with error
    step(1'b0, 1'b1, 1'b1, 15'h6000, {2{64'h5555_6666_7777_8888}}, '1, 1'b1, acc, acc_dut);
    step(1'b0, 1'b1, 1'b0, 15'h6000, '0, '0, 1'b1, acc, acc_dut);
    drain();

    // Credit backpressure with the response port stalled
    t4_addr = '{15'h0000, 15'h5801, 15'h6000, 15'h0000, 15'h5801, 15'h6000};
    k = 0; n_dut = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b1, 1'b0, t4_addr[k], '0, '0, 1'b0, acc, acc_dut);
      if (acc) k++;
      if (acc_dut) n_dut++;
    end
    check("stalled_reads_accepted", DW'(n_dut), DW'(4));
    check("stalled_req_ready", DW'(req_ready), '0);
    step(1'b0, 1'b1, 1'b1, 15'h0100, {2{64'h0F0F_0F0F_0F0F_0F0F}}, '1, 1'b0, acc, acc_dut);
    check("write_while_full", DW'(acc_dut), DW'(1));
    n_dut = 0;
    for (int c = 0; c < 30 && (k < 6 || exp_q.size() > 0); c++) begin
      if (k < 6) begin
        step(1'b0, 1'b1, 1'b0, t4_addr[k], '0, '0, 1'b1, acc, acc_dut);
        if (acc) k++;
        if (acc_dut) n_dut++;
      end else begin
        idle(1'b1);
      end
    end
    check("remaining_reads_accepted", DW'(n_dut), DW'(2));
    drain();

    // Reset with reads in S1, S2 and the FIFO
    step(1'b0, 1'b1, 1'b0, 15'h0000, '0, '0, 1'b0, acc, acc_dut);
    step(1'b0, 1'b1, 1'b0, 15'h5801, '0, '0, 1'b0, acc, acc_dut);
    step(1'b0, 1'b1, 1'b0, 15'h0100, '0, '0, 1'b0, acc, acc_dut);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, acc, acc_dut);
    for (int c = 0; c < 6; c++) idle(1'b1);

    // Randomised mixed traffic over a small address pool (frequent RAW)
    pool = '{15'h0000, 15'h07FF, 15'h0800, 15'h2ABC, 15'h5801, 15'h5FFF,
             15'h1234, 15'h4321, 15'h6000, 15'h7FFF, 15'h3000, 15'h5800};
    foreach (pool[i]) step(1'b0, 1'b1, 1'b1, pool[i], rnd_word(), '1, 1'b1, acc, acc_dut);
    last_a = pool[0];
    for (int c = 0; c < 800; c++) begin
      a = ($urandom_range(0, 3) == 0) ? last_a : pool[$urandom_range(0, 11)];
      case ($urandom_range(0, 2))
        0:       bm = '1;
        1:       bm = {{64{1'b0}}, {64{1'b1}}};
        default: bm = rnd_word();
      endcase
      step(1'b0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 4, a, rnd_word(), bm,
           $urandom_range(0, 9) < 7, acc, acc_dut);
      if (acc) last_a = a;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
